// File: rtl/color_box_detect.sv
// Colour-window bounding-box detector.
// Classifies each RGB444 pixel against a per-channel window latched at start of frame.
// Accumulates the bounding box and match count of matching pixels.
// Publishes the closed frame's result when the next start-of-frame arrives.
module color_box_detect #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    localparam int XW = $clog2(IMG_WIDTH),
    localparam int YW = $clog2(IMG_HEIGHT),
    localparam int CW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1)
) (
    input  logic          i_pclk,
    input  logic          i_rst,
    input  logic          i_sof,
    input  logic          i_wr,
    input  logic [11:0]   i_wdata,
    input  logic [3:0]    i_r_min,
    input  logic [3:0]    i_r_max,
    input  logic [3:0]    i_g_min,
    input  logic [3:0]    i_g_max,
    input  logic [3:0]    i_b_min,
    input  logic [3:0]    i_b_max,
    output logic          o_match,
    output logic          o_match_valid,
    output logic          o_box_valid,
    output logic          o_found,
    output logic [XW-1:0] o_x_min,
    output logic [XW-1:0] o_x_max,
    output logic [YW-1:0] o_y_min,
    output logic [YW-1:0] o_y_max,
    output logic [CW-1:0] o_count,
    output logic          o_overrun
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state;

    // Shadow thresholds
    logic [3:0] sh_r_min, sh_r_max, sh_g_min, sh_g_max, sh_b_min, sh_b_max;

    // Position counters; full marks that every in-range position has been used
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          full;

    // Frame accumulators
    logic          acc_found;
    logic [XW-1:0] acc_x_min, acc_x_max;
    logic [YW-1:0] acc_y_min, acc_y_max;
    logic [CW-1:0] acc_count;
    logic          acc_ovr;

    // Combinational next-state values
    logic [3:0]    th_r_min, th_r_max, th_g_min, th_g_max, th_b_min, th_b_max;
    logic          accept, pix_match, hit;
    logic [XW-1:0] cur_x, nxt_x;
    logic [YW-1:0] cur_y, nxt_y;
    logic          cur_full, nxt_full;
    logic          base_found, nxt_found;
    logic [XW-1:0] base_x_min, base_x_max, nxt_x_min, nxt_x_max;
    logic [YW-1:0] base_y_min, base_y_max, nxt_y_min, nxt_y_max;
    logic [CW-1:0] base_count, nxt_count;
    logic          base_ovr, nxt_ovr;

    // Classify the incoming pixel and compute next counter/accumulator values.
    // A pixel coincident with sof belongs to the new frame: it sees the incoming
    // thresholds and starts from cleared counters and accumulators.
    always_comb begin
        th_r_min = i_sof ? i_r_min : sh_r_min;
        th_r_max = i_sof ? i_r_max : sh_r_max;
        th_g_min = i_sof ? i_g_min : sh_g_min;
        th_g_max = i_sof ? i_g_max : sh_g_max;
        th_b_min = i_sof ? i_b_min : sh_b_min;
        th_b_max = i_sof ? i_b_max : sh_b_max;

        accept    = i_wr && ((state == ACTIVE) || i_sof);
        pix_match = (th_r_min <= i_wdata[11:8]) && (i_wdata[11:8] <= th_r_max) &&
                    (th_g_min <= i_wdata[7:4])  && (i_wdata[7:4]  <= th_g_max) &&
                    (th_b_min <= i_wdata[3:0])  && (i_wdata[3:0]  <= th_b_max);

        cur_x      = i_sof ? '0   : x_cnt;
        cur_y      = i_sof ? '0   : y_cnt;
        cur_full   = i_sof ? 1'b0 : full;
        base_found = i_sof ? 1'b0 : acc_found;
        base_x_min = i_sof ? '0   : acc_x_min;
        base_x_max = i_sof ? '0   : acc_x_max;
        base_y_min = i_sof ? '0   : acc_y_min;
        base_y_max = i_sof ? '0   : acc_y_max;
        base_count = i_sof ? '0   : acc_count;
        base_ovr   = i_sof ? 1'b0 : acc_ovr;

        hit = accept && !cur_full && pix_match;

        nxt_x    = cur_x;
        nxt_y    = cur_y;
        nxt_full = cur_full;
        if (accept && !cur_full) begin
            if (cur_x == X_LAST) begin
                nxt_x = '0;
                if (cur_y == Y_LAST)
                    nxt_full = 1'b1;
                else
                    nxt_y = cur_y + YW'(1);
            end else begin
                nxt_x = cur_x + XW'(1);
            end
        end

        nxt_ovr   = base_ovr | (accept & cur_full);
        nxt_found = base_found | hit;
        nxt_count = base_count + CW'(hit);

        nxt_x_min = base_x_min;
        nxt_x_max = base_x_max;
        nxt_y_min = base_y_min;
        nxt_y_max = base_y_max;
        if (hit) begin
            if (!base_found) begin
                nxt_x_min = cur_x;
                nxt_x_max = cur_x;
                nxt_y_min = cur_y;
                nxt_y_max = cur_y;
            end else begin
                if (cur_x < base_x_min) nxt_x_min = cur_x;
                if (cur_x > base_x_max) nxt_x_max = cur_x;
                if (cur_y < base_y_min) nxt_y_min = cur_y;
                if (cur_y > base_y_max) nxt_y_max = cur_y;
            end
        end
    end

    // FSM, shadow thresholds, position counters and frame accumulators.
    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            sh_r_min  <= '0;
            sh_r_max  <= '0;
            sh_g_min  <= '0;
            sh_g_max  <= '0;
            sh_b_min  <= '0;
            sh_b_max  <= '0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            full      <= 1'b0;
            acc_found <= 1'b0;
            acc_x_min <= '0;
            acc_x_max <= '0;
            acc_y_min <= '0;
            acc_y_max <= '0;
            acc_count <= '0;
            acc_ovr   <= 1'b0;
        end else begin
            if (i_sof) begin
                state    <= ACTIVE;
                sh_r_min <= i_r_min;
                sh_r_max <= i_r_max;
                sh_g_min <= i_g_min;
                sh_g_max <= i_g_max;
                sh_b_min <= i_b_min;
                sh_b_max <= i_b_max;
            end
            x_cnt     <= nxt_x;
            y_cnt     <= nxt_y;
            full      <= nxt_full;
            acc_found <= nxt_found;
            acc_x_min <= nxt_x_min;
            acc_x_max <= nxt_x_max;
            acc_y_min <= nxt_y_min;
            acc_y_max <= nxt_y_max;
            acc_count <= nxt_count;
            acc_ovr   <= nxt_ovr;
        end
    end

    // Registered per-pixel flag and frame-result publication on sof in ACTIVE.
    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            o_match       <= 1'b0;
            o_match_valid <= 1'b0;
            o_box_valid   <= 1'b0;
            o_found       <= 1'b0;
            o_x_min       <= '0;
            o_x_max       <= '0;
            o_y_min       <= '0;
            o_y_max       <= '0;
            o_count       <= '0;
            o_overrun     <= 1'b0;
        end else begin
            o_match       <= hit;
            o_match_valid <= accept;
            o_box_valid   <= i_sof && (state == ACTIVE);
            if (i_sof && (state == ACTIVE)) begin
                o_found   <= acc_found;
                o_x_min   <= acc_x_min;
                o_x_max   <= acc_x_max;
                o_y_min   <= acc_y_min;
                o_y_max   <= acc_y_max;
                o_count   <= acc_count;
                o_overrun <= acc_ovr;
            end
        end
    end

endmodule

// File: tb/tb_color_box_detect.sv
// Self-checking bench for color_box_detect on a reduced 20x12 image.
module tb_color_box_detect;

    localparam int W  = 20;
    localparam int H  = 12;
    localparam int N  = W * H;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst, sof, wr;
    logic [11:0]   wdata;
    logic [3:0]    r_min, r_max, g_min, g_max, b_min, b_max;
    logic          o_match, o_match_valid, o_box_valid, o_found, o_overrun;
    logic [XW-1:0] o_x_min, o_x_max;
    logic [YW-1:0] o_y_min, o_y_max;
    logic [CW-1:0] o_count;

    int checks = 0;
    int errors = 0;

    color_box_detect #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .i_pclk(clk), .i_rst(rst), .i_sof(sof), .i_wr(wr), .i_wdata(wdata),
        .i_r_min(r_min), .i_r_max(r_max), .i_g_min(g_min), .i_g_max(g_max),
        .i_b_min(b_min), .i_b_max(b_max),
        .o_match(o_match), .o_match_valid(o_match_valid), .o_box_valid(o_box_valid),
        .o_found(o_found), .o_x_min(o_x_min), .o_x_max(o_x_max),
        .o_y_min(o_y_min), .o_y_max(o_y_max), .o_count(o_count), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Stores every pixel of the current frame; the frame result is recomputed
    // from the stored list when the frame closes.
    logic [11:0] fq[$];
    logic [3:0]  th[6];
    bit          m_active = 0;
    int e_mv = 0, e_m = 0, e_bv = 0;
    int e_found = 0, e_xmin = 0, e_xmax = 0, e_ymin = 0, e_ymax = 0, e_cnt = 0, e_ovr = 0;

    function automatic bit pix_ok(input logic [11:0] p);
        return (th[0] <= p[11:8]) && (p[11:8] <= th[1]) &&
               (th[2] <= p[7:4])  && (p[7:4]  <= th[3]) &&
               (th[4] <= p[3:0])  && (p[3:0]  <= th[5]);
    endfunction

    function automatic void publish();
        int x, y;
        e_found = 0; e_cnt = 0; e_ovr = 0;
        e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
        foreach (fq[i]) begin
            if (i >= N) e_ovr = 1;
            else if (pix_ok(fq[i])) begin
                x = i % W;
                y = i / W;
                if (e_found == 0) begin
                    e_xmin = x; e_xmax = x; e_ymin = y; e_ymax = y;
                end else begin
                    e_xmin = (x < e_xmin) ? x : e_xmin;
                    e_xmax = (x > e_xmax) ? x : e_xmax;
                    e_ymin = (y < e_ymin) ? y : e_ymin;
                    e_ymax = (y > e_ymax) ? y : e_ymax;
                end
                e_found = 1;
                e_cnt++;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0;
            fq.delete();
            foreach (th[i]) th[i] = 4'h0;
            e_mv = 0; e_m = 0; e_bv = 0;
            e_found = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_cnt = 0; e_ovr = 0;
        end else begin
            e_mv = 0; e_m = 0; e_bv = 0;
            if (sof) begin
                if (m_active) begin
                    publish();
                    e_bv = 1;
                end
                fq.delete();
                th[0] = r_min; th[1] = r_max; th[2] = g_min;
                th[3] = g_max; th[4] = b_min; th[5] = b_max;
                m_active = 1;
            end
            if (wr && m_active) begin
                e_mv = 1;
                e_m  = (fq.size() < N && pix_ok(wdata)) ? 1 : 0;
                fq.push_back(wdata);
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(posedge clk) begin
        #2;
        chk("match_valid", int'(o_match_valid), e_mv);
        chk("match",       int'(o_match),       e_m);
        chk("box_valid",   int'(o_box_valid),   e_bv);
        chk("found",       int'(o_found),       e_found);
        chk("x_min",       int'(o_x_min),       e_xmin);
        chk("x_max",       int'(o_x_max),       e_xmax);
        chk("y_min",       int'(o_y_min),       e_ymin);
        chk("y_max",       int'(o_y_max),       e_ymax);
        chk("count",       int'(o_count),       e_cnt);
        chk("overrun",     int'(o_overrun),     e_ovr);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit s, input bit w, input logic [11:0] d);
        @(negedge clk);
        sof = s; wr = w; wdata = d;
    endtask

    task automatic sof_cyc(input bit w, input logic [11:0] d,
                           input logic [3:0] rl, rh, gl, gh, bl, bh);
        @(negedge clk);
        sof = 1'b1; wr = w; wdata = d;
        r_min = rl; r_max = rh; g_min = gl; g_max = gh; b_min = bl; b_max = bh;
    endtask

    task automatic frame(input int n, input logic [11:0] bg,
                         input int i0, input int i1, input int i2, input logic [11:0] sp);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b1, (i == i0 || i == i1 || i == i2) ? sp : bg);
        cyc(1'b0, 1'b0, 12'h000);
    endtask

    // Hand-computed frame result, checked on both DUT and model
    task automatic pub_chk(input string name, input int f, input int xl, input int xh,
                           input int yl, input int yh, input int c, input int ov);
        @(posedge clk);
        #2;
        chk({name, "_box_valid"}, int'(o_box_valid), 1);
        chk({name, "_found"},     int'(o_found),     f);
        chk({name, "_x_min"},     int'(o_x_min),     xl);
        chk({name, "_x_max"},     int'(o_x_max),     xh);
        chk({name, "_y_min"},     int'(o_y_min),     yl);
        chk({name, "_y_max"},     int'(o_y_max),     yh);
        chk({name, "_count"},     int'(o_count),     c);
        chk({name, "_overrun"},   int'(o_overrun),   ov);
        chk({name, "_model_count"}, e_cnt,  c);
        chk({name, "_model_xmax"},  e_xmax, xh);
        chk({name, "_model_ymax"},  e_ymax, yh);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sof = 1'b0; wr = 1'b0; wdata = 12'h000;
        r_min = 4'h0; r_max = 4'h0; g_min = 4'h0; g_max = 4'h0; b_min = 4'h0; b_max = 4'h0;
        repeat (3) @(negedge clk);
        chk("reset_box_valid", int'(o_box_valid), 0);
        chk("reset_count",     int'(o_count),     0);
        chk("reset_found",     int'(o_found),     0);
        chk("reset_mvalid",    int'(o_match_valid), 0);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 12'hFFF);   // ignored in IDLE
        cyc(1'b0, 1'b0, 12'h000);

        // First sof after reset: no publish
        sof_cyc(1'b0, 12'h000, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        @(posedge clk); #2;
        chk("first_sof_no_pub", int'(o_box_valid), 0);
        frame(N, 12'h000, 5 * W + 10, -1, -1, 12'hFFF);

        sof_cyc(1'b0, 12'h000, 4'h8, 4'hF, 4'h0, 4'h3, 4'h0, 4'h3);
        pub_chk("one_px", 1, 10, 10, 5, 5, 1, 0);
        frame(N, 12'h000, 2 * W + 3, 9 * W + 18, 11 * W + 9, 12'hF00);

        sof_cyc(1'b0, 12'h000, 4'h8, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        pub_chk("three_px", 1, 3, 18, 2, 11, 3, 0);
        frame(50, 12'h0F0, -1, -1, -1, 12'h000);   // short frame, no matches

        sof_cyc(1'b0, 12'h000, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF);
        pub_chk("no_match", 0, 0, 0, 0, 0, 0, 0);
        frame(N + 5, 12'h123, -1, -1, -1, 12'h000);

        sof_cyc(1'b0, 12'h000, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF);
        pub_chk("overrun", 1, 0, W - 1, 0, H - 1, N, 1);
        frame(3, 12'h123, -1, -1, -1, 12'h000);

        // sof with coincident pixel and new thresholds
        sof_cyc(1'b1, 12'hABC, 4'hA, 4'hA, 4'hB, 4'hB, 4'hC, 4'hC);
        pub_chk("sof_wr_close", 1, 0, 2, 0, 0, 3, 0);
        chk("sof_wr_match", int'(o_match), 1);
        chk("sof_wr_mvalid", int'(o_match_valid), 1);
        cyc(1'b0, 1'b1, 12'hABD);
        cyc(1'b0, 1'b0, 12'h000);

        // red window min>max never matches
        sof_cyc(1'b0, 12'h000, 4'h5, 4'h3, 4'h0, 4'hF, 4'h0, 4'hF);
        pub_chk("sof_wr_next", 1, 0, 0, 0, 0, 1, 0);
        frame(20, 12'hFFF, 0, 5, 9, 12'h444);

        sof_cyc(1'b0, 12'h000, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF);
        pub_chk("min_gt_max", 0, 0, 0, 0, 0, 0, 0);
        sof_cyc(1'b0, 12'h000, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF);
        pub_chk("back_to_back", 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-frame discards the partial frame
        frame(100, 12'h123, -1, -1, -1, 12'h000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #2;
        chk("midrst_count", int'(o_count), 0);
        chk("midrst_box_valid", int'(o_box_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 12'h000);
        sof_cyc(1'b0, 12'h000, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF);
        @(posedge clk); #2;
        chk("post_rst_first_sof", int'(o_box_valid), 0);
        cyc(1'b0, 1'b0, 12'h000);
        sof_cyc(1'b0, 12'h000, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF);
        pub_chk("after_reset", 0, 0, 0, 0, 0, 0, 0);
        cyc(1'b0, 1'b0, 12'h000);
        cyc(1'b0, 1'b0, 12'h000);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/color_box_detect.md
COLOR_BOX_DETECT -- requirements
Module: color_box_detect

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per row.
REQ-002 Parameter IMG_HEIGHT, default 480, rows per frame.
REQ-003 Port XW = $clog2(IMG_WIDTH) (10), YW = $clog2(IMG_HEIGHT) (9), CW = $clog2(IMG_WIDTH*IMG_HEIGHT+1) (19); derived localparams, not overridable.
REQ-004 i_pclk  in  1  sole clock; all logic on rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_sof  in  1  one-cycle start-of-frame pulse from capture stage.
REQ-007 i_wr  in  1  pixel-valid strobe from capture stage.
REQ-008 i_wdata  in  12  RGB444 pixel {R[11:8],G[7:4],B[3:0]}, valid when i_wr=1.
REQ-009 i_r_min, i_r_max, i_g_min, i_g_max, i_b_min, i_b_max  in  4 each  inclusive per-channel match window.
REQ-010 o_match  out  1  registered per-pixel match flag.
REQ-011 o_match_valid  out  1  qualifies o_match.
REQ-012 o_box_valid  out  1  one-cycle pulse: frame result registers updated.
REQ-013 o_found  out  1  at least one pixel matched in published frame.
REQ-014 o_x_min, o_x_max  out  XW  horizontal bounds of matched pixels.
REQ-015 o_y_min, o_y_max  out  YW  vertical bounds of matched pixels.
REQ-016 o_count  out  CW  matched-pixel count.
REQ-017 o_overrun  out  1  published frame received more than IMG_WIDTH*IMG_HEIGHT pixels.

Function
REQ-018 FSM states: IDLE (after reset, ignore i_wr) and ACTIVE; IDLE->ACTIVE on i_sof; ACTIVE stays ACTIVE; only reset returns to IDLE.
REQ-019 On every i_sof: latch all six threshold inputs into shadow registers, clear x/y counters, accumulators and overrun flag; thresholds used for matching come only from shadow registers.
REQ-020 Pixel match = R,G,B each within [min,max] inclusive of shadow thresholds; min>max on a channel means that channel never matches.
REQ-021 o_match/o_match_valid driven exactly 1 cycle after the accepted i_wr; o_match_valid=0 in cycles with no accepted pixel.
REQ-022 Accepted pixel: i_wr=1 in ACTIVE, or i_wr=1 coincident with i_sof; coordinate of first pixel after i_sof is (0,0).
REQ-023 x increments per accepted pixel; at x=IMG_WIDTH-1 wraps to 0 and y increments.
REQ-024 Pixel arriving when y would exceed IMG_HEIGHT-1: not matched into box/count, sets overrun flag, o_match_valid still pulses with o_match=0; counters hold.
REQ-025 On matched in-range pixel: count+1; x_min/x_max/y_min/y_max updated by compare; first match of frame loads all four bounds with its coordinate.
REQ-026 i_sof in ACTIVE closes current frame: next cycle outputs o_found, bounds, o_count, o_overrun updated and o_box_valid=1 for exactly one cycle; values hold until next publish.
REQ-027 Frame with no matches publishes o_found=0, bounds=0, o_count=0.
REQ-028 Short frame (fewer pixels than IMG_WIDTH*IMG_HEIGHT) publishes normally; no error flag.
REQ-029 i_sof with i_wr same cycle: closing frame excludes that pixel; pixel is (0,0) of new frame evaluated against newly latched thresholds.
REQ-030 First i_sof after reset (IDLE->ACTIVE) does not publish; o_box_valid stays 0.
REQ-031 Back-to-back i_sof pulses: each in ACTIVE publishes; an empty frame publishes as in REQ-027.
REQ-032 Count saturates never; CW sized to hold IMG_WIDTH*IMG_HEIGHT.

Reset
REQ-033 i_rst=1 asynchronously forces IDLE, all outputs 0, counters, accumulators, shadow thresholds and flags 0.
REQ-034 Reset mid-frame discards partial frame; no o_box_valid pulse generated by reset or its release.

Verification
REQ-035 Reset, sof, one 640x480 frame, thresholds R,G,B all [0xF,0xF], single pixel 0xFFF at (100,50), sof -> o_box_valid pulse, o_found=1, bounds x 100/100, y 50/50, o_count=1.
REQ-036 Thresholds R [8,15], G [0,3], B [0,3]; pixels 0xF00 at (10,5),(600,400),(320,479), others 0x000 -> x 10/600, y 5/479, count 3, o_overrun=0.
REQ-037 Frame of all 0x0F0 with red-only window -> o_found=0, bounds 0, count 0; per-pixel o_match=0 with o_match_valid 1 cycle after each i_wr.
REQ-038 Frame of 640*480+5 pixels, all matching -> o_overrun=1, o_count=307200, x 0/639, y 0/479.
REQ-039 i_sof coincident with i_wr of matching pixel, threshold inputs changed same cycle -> closing frame excludes it; next frame reports (0,0) match under new thresholds.
REQ-040 Assert i_rst mid-frame after 1000 matches, release, sof, sof -> no pulse until second sof; published count=0.
